// File: rtl/chip8_pkg.sv
// Shared constants and fetch-state encoding for the CHIP-8 core.
// The FAULT state exists only when CHIP8_FETCH_ALIGN_CHK_EN is defined.
package chip8_pkg;

  localparam int          ADDR_W       = 12;
  localparam logic [11:0] PC_RESET     = 12'h200;
  localparam int          PC_STEP      = 2;
  localparam int          PC_SKIP_STEP = 4;

  typedef enum logic [2:0] {
    RD_HI = 3'd0,
    WT_HI = 3'd1,
    RD_LO = 3'd2,
    WT_LO = 3'd3,
    HOLD  = 3'd4
`ifdef CHIP8_FETCH_ALIGN_CHK_EN
    ,
    FAULT = 3'd5
`endif
  } fetch_state_e;

endpackage

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: two byte reads per opcode, valid/ready to decode.
// Define CHIP8_FETCH_ALIGN_CHK_EN to add the odd-jump-target fault port/state.
//
// state | meaning
// RD_HI | issue read of byte at pc (held off until the first cycle after reset)
// WT_HI | wait for high byte
// RD_LO | issue read of byte at pc+1
// WT_LO | wait for low byte
// HOLD  | instruction offered; PC update on handshake
// FAULT | odd jump target taken; fetch stopped until reset (optional)
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int                ADDR_W   = chip8_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(chip8_pkg::PC_RESET)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
`ifdef CHIP8_FETCH_ALIGN_CHK_EN
  output logic              fault,
`endif
  input  logic              pc_skip
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt, pc_inc1, addr_q;
  logic [15:0]       instr_q;
  logic              started;
  logic              handshake;

  assign pc_inc1   = pc_q + ADDR_W'(1);
  assign handshake = (state == HOLD) && instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RD_HI;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_HI: if (started) state_nxt = WT_HI;
      WT_HI: if (mem_valid) state_nxt = RD_LO;
      RD_LO: state_nxt = WT_LO;
      WT_LO: if (mem_valid) state_nxt = HOLD;
      HOLD: begin
        if (instr_ready) begin
          state_nxt = RD_HI;
`ifdef CHIP8_FETCH_ALIGN_CHK_EN
          if (pc_load && pc_load_addr[0]) state_nxt = FAULT;
`endif
        end
      end
`ifdef CHIP8_FETCH_ALIGN_CHK_EN
      FAULT: state_nxt = FAULT;
`endif
      default: state_nxt = RD_HI;
    endcase
  end

  // mem_addr falls back to the last driven address whenever no read is issued
  always_comb begin
    instr_valid = (state == HOLD);
    mem_rd      = ((state == RD_HI) && started) || (state == RD_LO);
    mem_addr    = addr_q;
    if (state == RD_LO)                 mem_addr = pc_inc1;
    else if ((state == RD_HI) && started) mem_addr = pc_q;
  end

  always_comb begin
    pc_nxt = pc_q + ADDR_W'(PC_STEP);
    if (pc_load)      pc_nxt = pc_load_addr;
    else if (pc_skip) pc_nxt = pc_q + ADDR_W'(PC_SKIP_STEP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= PC_RESET;
      instr_q <= 16'h0000;
      addr_q  <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      addr_q  <= mem_addr;
      if ((state == WT_HI) && mem_valid) instr_q[15:8] <= mem_rdata;
      if ((state == WT_LO) && mem_valid) instr_q[7:0]  <= mem_rdata;
      if (handshake) pc_q <= pc_nxt;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;

`ifdef CHIP8_FETCH_ALIGN_CHK_EN
  assign fault = (state == FAULT);
`endif

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed bench for chip8_fetch with a variable-latency byte memory model.
// Build with CHIP8_FETCH_ALIGN_CHK_EN to exercise the odd-target fault path.
`timescale 1ns/1ps
module tb_chip8_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [11:0] pc;
  logic        pc_load = 1'b0;
  logic [11:0] pc_load_addr = 12'h000;
  logic        pc_skip = 1'b0;
`ifdef CHIP8_FETCH_ALIGN_CHK_EN
  logic        fault;
`endif

  logic [7:0]  image [4096];
  int          lat = 1;
  logic        resp_valid = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        inj_valid = 1'b0;
  logic [7:0]  inj_data = 8'h00;
  logic        pend = 1'b0;
  logic [11:0] paddr = 12'h000;
  int          cnt = 0;
  logic        rd_s = 1'b0;
  logic [11:0] a_s = 12'h000;
  int          nvec = 0;
  int          nerr = 0;

  chip8_fetch dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
`ifdef CHIP8_FETCH_ALIGN_CHK_EN
    .fault(fault),
`endif
    .pc_skip(pc_skip)
  );

  always #5 clk = ~clk;

  assign mem_valid = resp_valid | inj_valid;
  assign mem_rdata = inj_valid ? inj_data : resp_data;

  always @(negedge clk) begin
    rd_s = mem_rd;
    a_s  = mem_addr;
  end

  // Read issued in cycle k returns data during cycle k+lat.
  always @(posedge clk) begin
    #1;
    resp_valid = 1'b0;
    if (rd_s) begin
      pend  = 1'b1;
      paddr = a_s;
      cnt   = lat;
    end
    if (pend) begin
      if (cnt <= 1) begin
        resp_valid = 1'b1;
        resp_data  = image[paddr];
        pend       = 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_ins(input logic [11:0] p);
    logic [11:0] p1;
    p1 = p + 12'd1;
    return {image[p], image[p1]};
  endfunction

  // Steps until instr_valid; reports elapsed cycles and the first two read addresses.
  task automatic wait_valid(input logic spur, output int cyc,
                            output logic [11:0] a0, output logic [11:0] a1);
    int n;
    n   = 0;
    cyc = 0;
    a0  = 12'hxxx;
    a1  = 12'hxxx;
    if (spur) begin
      inj_valid = 1'b1;
      inj_data  = 8'hEE;
    end
    if (mem_rd) begin
      a0 = mem_addr;
      n++;
    end
    while (!instr_valid && cyc < 40) begin
      step();
      inj_valid = 1'b0;
      cyc++;
      if (mem_rd) begin
        if (n == 0) a0 = mem_addr;
        else if (n == 1) a1 = mem_addr;
        n++;
      end
    end
  endtask

  task automatic accept(input logic ld, input logic [11:0] la, input logic sk);
    pc_load      = ld;
    pc_load_addr = la;
    pc_skip      = sk;
    instr_ready  = 1'b1;
    step();
    instr_ready  = 1'b0;
    pc_load      = 1'b0;
    pc_skip      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [11:0] a0, a1;
    logic [15:0] inst0;
    logic [11:0] pc0;
    int          bad;
    int          exp_pc;

    for (int i = 0; i < 4096; i++) image[i] = 8'(i) ^ 8'(i >> 4) ^ 8'h5A;
    image[12'h200] = 8'h12;
    image[12'h201] = 8'h34;
    image[12'hFFE] = 8'h9F;
    image[12'hFFF] = 8'hAB;
    image[12'h000] = 8'hCD;

    // Reset values, then first fetch
    step();
    step();
    chk("rst_valid", 16'(instr_valid), 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_pc", 16'(pc), 16'h0200);
    chk("rst_mem_rd", 16'(mem_rd), 16'h0000);
    chk("rst_mem_addr", 16'(mem_addr), 16'h0000);
`ifdef CHIP8_FETCH_ALIGN_CHK_EN
    chk("rst_fault", 16'(fault), 16'h0000);
`endif
    rst = 1'b1;
    wait_valid(1'b0, cyc, a0, a1);
    chk("first_latency", 16'(cyc), 16'd5);
    chk("first_rd_hi", 16'(a0), 16'h0200);
    chk("first_rd_lo", 16'(a1), 16'h0201);
    chk("first_instr", instruction, 16'h1234);
    chk("first_pc", 16'(pc), 16'h0200);

    // Backpressure: stable offer, no reads, stray mem_valid and redirect ignored
    inst0 = instruction;
    pc0   = pc;
    bad   = 0;
    pc_load = 1'b1; pc_skip = 1'b1; pc_load_addr = 12'h500;
    for (int i = 0; i < 10; i++) begin
      inj_valid = i[0];
      inj_data  = 8'hEE;
      step();
      if (instruction !== inst0 || pc !== pc0 || mem_rd !== 1'b0 || instr_valid !== 1'b1) bad++;
    end
    inj_valid = 1'b0;
    pc_load = 1'b0; pc_skip = 1'b0;
    chk("hold_stable", 16'(bad), 16'd0);
    chk("hold_instr", instruction, 16'h1234);

    accept(1'b0, 12'h000, 1'b0);
    wait_valid(1'b1, cyc, a0, a1);
    chk("plain_rd", 16'(a0), 16'h0202);
    chk("plain_pc", 16'(pc), 16'h0202);
    chk("plain_instr", instruction, exp_ins(12'h202));
    chk("plain_latency", 16'(cyc), 16'd4);

    accept(1'b1, 12'h3A0, 1'b1);
    wait_valid(1'b0, cyc, a0, a1);
    chk("load_wins_rd", 16'(a0), 16'h03A0);
    chk("load_wins_pc", 16'(pc), 16'h03A0);
    chk("load_wins_instr", instruction, exp_ins(12'h3A0));

    accept(1'b1, 12'h200, 1'b0);
    wait_valid(1'b0, cyc, a0, a1);
    accept(1'b0, 12'h000, 1'b1);
    wait_valid(1'b0, cyc, a0, a1);
    chk("skip_rd", 16'(a0), 16'h0204);
    chk("skip_pc", 16'(pc), 16'h0204);

    // Wrap-around
    accept(1'b1, 12'hFFE, 1'b0);
    wait_valid(1'b0, cyc, a0, a1);
    chk("ffe_instr", instruction, 16'h9FAB);
    accept(1'b0, 12'h000, 1'b0);
    wait_valid(1'b0, cyc, a0, a1);
    chk("wrap2_pc", 16'(pc), 16'h0000);
    chk("wrap2_instr", instruction, {8'hCD, image[12'h001]});
    accept(1'b1, 12'hFFE, 1'b0);
    wait_valid(1'b0, cyc, a0, a1);
    accept(1'b0, 12'h000, 1'b1);
    wait_valid(1'b0, cyc, a0, a1);
    chk("wrap4_pc", 16'(pc), 16'h0002);

    // Memory latency 2..4 with stray mem_valid in RD_HI and HOLD
    exp_pc = 2;
    for (int l = 2; l <= 4; l++) begin
      lat = l;
      inj_valid = 1'b1;
      inj_data  = 8'hEE;
      step();
      inj_valid = 1'b0;
      chk("spur_hold", instruction, exp_ins(12'(exp_pc)));
      accept(1'b0, 12'h000, 1'b0);
      exp_pc += 2;
      wait_valid(1'b1, cyc, a0, a1);
      chk("lat_cycles", 16'(cyc), 16'(4 + 2 * (l - 1)));
      chk("lat_pc", 16'(pc), 16'(exp_pc));
      chk("lat_instr", instruction, exp_ins(12'(exp_pc)));
    end
    lat = 1;

    // Reset while waiting for the low byte; the late response must be ignored
    accept(1'b0, 12'h000, 1'b0);
    cyc = 0;
    while (!(mem_rd === 1'b1 && mem_addr === 12'h00B) && cyc < 40) begin
      step();
      cyc++;
    end
    chk("reach_rd_lo", 16'(mem_addr), 16'h000B);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 16'(instr_valid), 16'h0000);
    chk("midrst_instr", instruction, 16'h0000);
    chk("midrst_pc", 16'(pc), 16'h0200);
    chk("midrst_mem_rd", 16'(mem_rd), 16'h0000);
    chk("midrst_mem_addr", 16'(mem_addr), 16'h0000);
    step();
    rst = 1'b1;
    wait_valid(1'b1, cyc, a0, a1);
    chk("postrst_latency", 16'(cyc), 16'd5);
    chk("postrst_rd", 16'(a0), 16'h0200);
    chk("postrst_instr", instruction, 16'h1234);

`ifdef CHIP8_FETCH_ALIGN_CHK_EN
    accept(1'b1, 12'h201, 1'b0);
    chk("fault_set", 16'(fault), 16'h0001);
    chk("fault_pc", 16'(pc), 16'h0201);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_rd !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b1) bad++;
      step();
    end
    chk("fault_quiet", 16'(bad), 16'd0);
`else
    accept(1'b1, 12'hFFF, 1'b0);
    wait_valid(1'b0, cyc, a0, a1);
    chk("odd_rd_hi", 16'(a0), 16'h0FFF);
    chk("odd_rd_lo", 16'(a1), 16'h0000);
    chk("odd_instr", instruction, 16'hABCD);
    chk("odd_pc", 16'(pc), 16'h0FFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
